// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO plus drain controller placed directly in front of uart_tx.
//   Producers push bytes at up to one per clock. The drain FSM hands bytes to
//   uart_tx one at a time over its DV/Byte handshake and paces itself on
//   uart_tx's Active/Done outputs. Producers see only full/overflow status.
//
// Ports
//   i_Clock      system clock (same clock as uart_tx)
//   i_Reset      synchronous, active-high reset
//   i_Wr_DV      write strobe, one byte per cycle while high
//   i_Wr_Byte    write data
//   o_Full       FIFO holds DEPTH entries
//   o_Empty      FIFO holds 0 entries
//   o_Count      occupancy, 0..DEPTH
//   o_Overflow   sticky: a write was dropped because the FIFO was full
//   o_Busy       FIFO not empty or drain FSM not idle
//   o_Tx_DV      to uart_tx i_Tx_DV, single-cycle launch pulse
//   o_Tx_Byte    to uart_tx i_Tx_Byte, valid while o_Tx_DV is high
//   i_Tx_Active  from uart_tx o_Tx_Active
//   i_Tx_Done    from uart_tx o_Tx_Done
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_DV,
    input  logic [7:0]        i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Busy,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_ACTIVE = 2'd1,
        S_WAIT_DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, empty_q, overflow_q;
    state_t            state_q;
    logic              tx_dv_q;
    logic [7:0]        tx_byte_q;

    logic push, pop;

    // Full is judged on the pre-edge count, so a write on the same edge as a
    // pop from a full FIFO is still dropped.
    assign push = i_Wr_DV && (count_q != DEPTH_C);

    // Launch only when uart_tx is truly idle. Done stays high through
    // uart_tx's cleanup cycle and its first idle cycle; a DV during cleanup
    // would be ignored, so Done must also be low.
    assign pop = (state_q == S_IDLE) && !empty_q && !i_Tx_Active && !i_Tx_Done;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage has no reset; only pointers and count define its contents.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_Wr_Byte;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (i_Wr_DV && !push) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
        end
    end

    // Drain FSM with registered launch outputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            tx_dv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        tx_dv_q   <= 1'b1;
                        tx_byte_q <= mem_q[rd_ptr_q];
                        state_q   <= S_WAIT_ACTIVE;
                    end
                end
                S_WAIT_ACTIVE: begin
                    if (i_Tx_Active) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_Full     = full_q;
    assign o_Empty    = empty_q;
    assign o_Count    = count_q;
    assign o_Overflow = overflow_q;
    assign o_Tx_DV    = tx_dv_q;
    assign o_Tx_Byte  = tx_byte_q;
    assign o_Busy     = !empty_q || (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int CPB   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, wr_dv = 1'b0, hold = 1'b0;
    logic [7:0]    wr_byte = 8'h00;
    logic          full, empty, ovf, busy, tx_dv;
    logic [AW:0]   count;
    logic [7:0]    tx_byte;
    logic          u_act = 1'b0, u_done = 1'b0;
    logic          tx_active;

    // hold forces Active high to emulate a uart_tx that stays busy.
    assign tx_active = u_act | hold;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Wr_DV(wr_dv), .i_Wr_Byte(wr_byte),
        .o_Full(full), .o_Empty(empty), .o_Count(count), .o_Overflow(ovf),
        .o_Busy(busy), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
        .i_Tx_Active(tx_active), .i_Tx_Done(u_done)
    );

    int vec = 0, miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // uart_tx behavioural stand-in: frame of 10*CPB cycles, Done high for the
    // cleanup cycle and first idle cycle, DV ignored (flagged) when not idle.
    int         u_st = 0, u_cnt = 0, cyc = 0, last_done = 0, dv_bad = 0;
    logic [7:0] sent[$];
    int         gaps[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        case (u_st)
            0: begin
                u_done <= 1'b0;
                if (tx_dv === 1'b1) begin
                    u_act <= 1'b1;
                    u_cnt = 10 * CPB - 1;
                    u_st  = 1;
                    sent.push_back(tx_byte);
                    gaps.push_back(cyc - last_done);
                end
            end
            1: begin
                if (tx_dv === 1'b1) dv_bad++;
                if (u_cnt == 0) begin
                    u_act <= 1'b0;
                    u_done <= 1'b1;
                    u_st = 2;
                    last_done = cyc;
                end else begin
                    u_cnt--;
                end
            end
            default: begin
                if (tx_dv === 1'b1) dv_bad++;
                u_done <= 1'b1;
                u_st = 0;
            end
        endcase
    end

    // Reference model: a byte queue plus a "launch in flight" phase.
    logic [7:0] q[$];
    int         m_phase = 0;
    logic       m_dv = 1'b0, m_ovf = 1'b0;
    logic [7:0] m_byte = 8'h00;
    bit         mdl_en = 1'b0;

    always @(posedge clk) begin
        bit was_full;
        if (rst === 1'b1) begin
            q.delete();
            m_phase = 0; m_dv = 1'b0; m_byte = 8'h00; m_ovf = 1'b0;
            mdl_en = 1'b1;
        end else begin
            was_full = (q.size() == DEPTH);
            m_dv = 1'b0;
            case (m_phase)
                0: if (q.size() > 0 && !tx_active && !u_done) begin
                    m_dv = 1'b1;
                    m_byte = q.pop_front();
                    m_phase = 1;
                end
                1: if (tx_active) m_phase = 2;
                default: if (u_done) m_phase = 0;
            endcase
            if (wr_dv) begin
                if (was_full) m_ovf = 1'b1;
                else q.push_back(wr_byte);
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_en) begin
            chk("m_count", count, q.size());
            chk("m_full", full, q.size() == DEPTH);
            chk("m_empty", empty, q.size() == 0);
            chk("m_ovf", ovf, m_ovf);
            chk("m_busy", busy, (q.size() != 0) || (m_phase != 0));
            chk("m_dv", tx_dv, m_dv);
            chk("m_byte", tx_byte, m_byte);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        wr_dv = 1'b0;
        hold  = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || u_st != 0) && n < 2000);
        chk({nm, "_drain_in_time"}, (n < 2000), 1);
    endtask

    task automatic chk_seq(input string nm, input logic [7:0] base, input int n);
        chk({nm, "_len"}, sent.size(), n);
        for (int k = 0; k < n && k < sent.size(); k++)
            chk(nm, sent[k], base + k);
    endtask

    typedef struct {
        int rst, wr, b, hold;
        int cnt, full, empty, ovf, busy, dv;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int n;
        // rst wr byte hold | cnt full empty ovf busy dv
        tbl[0] = '{1, 0, 'h00, 1,  0, 0, 1, 0, 0, 0};
        tbl[1] = '{0, 1, 'hA0, 1,  1, 0, 0, 0, 1, 0};
        tbl[2] = '{0, 1, 'hA1, 1,  2, 0, 0, 0, 1, 0};
        tbl[3] = '{0, 1, 'hA2, 1,  3, 0, 0, 0, 1, 0};
        tbl[4] = '{0, 1, 'hA3, 1,  4, 1, 0, 0, 1, 0};
        tbl[5] = '{0, 1, 'hA4, 1,  4, 1, 0, 1, 1, 0};
        tbl[6] = '{0, 1, 'hA5, 1,  4, 1, 0, 1, 1, 0};
        tbl[7] = '{0, 0, 'h00, 1,  4, 1, 0, 1, 1, 0};

        // Reset, fill past full with uart_tx held busy.
        for (int i = 0; i < 8; i++) begin
            rst     = (tbl[i].rst != 0);
            wr_dv   = (tbl[i].wr != 0);
            wr_byte = tbl[i].b[7:0];
            hold    = (tbl[i].hold != 0);
            step();
            chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("tbl%0d_full", i), full, tbl[i].full);
            chk($sformatf("tbl%0d_empty", i), empty, tbl[i].empty);
            chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_dv", i), tx_dv, tbl[i].dv);
        end
        rst = 1'b0;
        drain("ovf");
        chk_seq("ovf_stream", 8'hA0, 4);
        chk("ovf_sticky", ovf, 1);

        // Single byte latency and busy release.
        rst = 1'b1; step(); rst = 1'b0;
        sent.delete();
        wr_dv = 1'b1; wr_byte = 8'h55;
        step();
        wr_dv = 1'b0;
        chk("lat_n_dv", tx_dv, 0);
        chk("lat_n_count", count, 1);
        step();
        chk("lat_n1_dv", tx_dv, 1);
        chk("lat_n1_byte", tx_byte, 8'h55);
        chk("lat_n1_count", count, 0);
        step();
        chk("lat_n2_dv", tx_dv, 0);
        chk("lat_hold_byte", tx_byte, 8'h55);
        n = 0;
        while (u_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("lat_done_seen", (n < 200), 1);
        chk("lat_busy_at_done", busy, 1);
        step();
        chk("lat_busy_after_done", busy, 0);
        drain("lat");
        chk_seq("lat_stream", 8'h55, 1);

        // Burst of three, back-to-back launch spacing.
        sent.delete(); gaps.delete();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_dv = 1'b1; wr_byte = 8'(k + 1);
            step();
            chk($sformatf("burst_count%0d", k), count, k + 1);
        end
        drain("burst");
        chk_seq("burst_stream", 8'h01, 3);
        chk("burst_gaps_len", gaps.size(), 3);
        if (gaps.size() == 3) begin
            chk("burst_gap1", gaps[1], 4);
            chk("burst_gap2", gaps[2], 4);
        end

        // Full FIFO: write and pop on the same edge.
        rst = 1'b1; step(); rst = 1'b0;
        sent.delete();
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_dv = 1'b1; wr_byte = 8'hB0 + 8'(k);
            step();
        end
        hold = 1'b0; wr_dv = 1'b1; wr_byte = 8'hBF;
        step();
        wr_dv = 1'b0;
        chk("fp_count", count, DEPTH - 1);
        chk("fp_ovf", ovf, 1);
        chk("fp_dv", tx_dv, 1);
        chk("fp_byte", tx_byte, 8'hB0);
        drain("fp");
        chk_seq("fp_stream", 8'hB0, 4);

        // Reset state, then slow writes that wrap the pointers.
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_byte", tx_byte, 8'h00);
        sent.delete();
        for (int k = 0; k < DEPTH + 3; k++) begin
            wr_dv = 1'b1; wr_byte = 8'hC0 + 8'(k);
            step();
            wr_dv = 1'b0;
            repeat (49) step();
        end
        drain("wrap");
        chk_seq("wrap_stream", 8'hC0, DEPTH + 3);
        chk("wrap_ovf", ovf, 0);

        // Reset in the middle of a frame with two bytes queued.
        rst = 1'b1; step(); rst = 1'b0;
        sent.delete();
        for (int k = 0; k < 3; k++) begin
            wr_dv = 1'b1; wr_byte = 8'hD0 + 8'(k);
            step();
        end
        wr_dv = 1'b0;
        repeat (15) step();
        chk("mid_pre_count", count, 2);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_count", count, 0);
        chk("mid_empty", empty, 1);
        chk("mid_ovf", ovf, 0);
        wr_dv = 1'b1; wr_byte = 8'h77;
        step();
        wr_dv = 1'b0;
        chk("mid_wait_dv", tx_dv, 0);
        drain("mid");
        chk("mid_len", sent.size(), 2);
        if (sent.size() == 2) begin
            chk("mid_first", sent[0], 8'hD0);
            chk("mid_second", sent[1], 8'h77);
        end

        // Randomized traffic against the model, heavy then light.
        for (int i = 0; i < 1500; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            wr_dv   = ($urandom_range(0, 99) < (i < 700 ? 40 : 3));
            wr_byte = 8'($urandom);
            step();
        end
        rst = 1'b0;
        drain("rand");
        chk("no_dv_while_uart_busy", dv_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO plus drain controller directly upstream of uart_tx.
- Producers (CPU bus, debug logic) push bytes at any rate up to one per clock.
- The block holds the bytes and launches them one at a time into uart_tx through its i_Tx_DV/i_Tx_Byte handshake, using o_Tx_Active/o_Tx_Done for pacing.
- Removes per-byte flow control from producers; only full/overflow status is exposed.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- ADDR_W, $clog2(DEPTH), pointer width (derived, do not override).

Ports:
- i_Clock  in  1  system clock, same clock as uart_tx.
- i_Reset  in  1  synchronous, active-high reset.
- i_Wr_DV  in  1  write strobe; one byte pushed per cycle while high.
- i_Wr_Byte  in  8  write data.
- o_Full  out  1  FIFO holds DEPTH entries.
- o_Empty  out  1  FIFO holds 0 entries.
- o_Count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- o_Overflow  out  1  sticky; a write was dropped.
- o_Busy  out  1  FIFO not empty OR drain FSM not in IDLE.
- o_Tx_DV  out  1  to uart_tx i_Tx_DV; single-cycle pulse.
- o_Tx_Byte  out  8  to uart_tx i_Tx_Byte; valid while o_Tx_DV high.
- i_Tx_Active  in  1  from uart_tx o_Tx_Active.
- i_Tx_Done  in  1  from uart_tx o_Tx_Done.

Behaviour:
- One clock domain; synchronous active-high reset on i_Reset; all outputs registered.
- Reset values: o_Tx_DV=0, o_Tx_Byte=0, o_Full=0, o_Empty=1, o_Count=0, o_Overflow=0, o_Busy=0. Pointers are 0 and the FSM is in IDLE.
- Storage: DEPTH x 8 register array. Write and read pointers are ADDR_W bits and wrap naturally at DEPTH. The count is tracked separately.
- Push: i_Wr_DV=1 and count<DEPTH at the sampling edge; the byte is stored and the write pointer and count increment.
- Push while full: i_Wr_DV=1 and count==DEPTH. The byte is dropped, o_Overflow sets and stays set until reset. This holds even if a pop occurs in the same cycle.
- Pop: performed only by the FSM at launch.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Flags o_Full, o_Empty and o_Count reflect the post-update count on the cycle after the edge.
- Drain FSM states:
  - IDLE: if count>0 AND i_Tx_Active=0 AND i_Tx_Done=0, then register o_Tx_DV=1 and o_Tx_Byte=mem[rd_ptr], pop, and go to WAIT_ACTIVE. Otherwise stay.
  - WAIT_ACTIVE: o_Tx_DV=0 (pulse is exactly 1 cycle). Stay until i_Tx_Active=1, then go to WAIT_DONE. No timeout.
  - WAIT_DONE: stay until i_Tx_Done=1, then go to IDLE.
  - Illegal state encodings go to IDLE.
- The i_Tx_Done guard in IDLE is required. uart_tx holds o_Tx_Done high through its cleanup cycle and its first idle cycle, and it ignores i_Tx_DV during cleanup. Gating on i_Tx_Done=0 guarantees the pulse lands while uart_tx is in idle.
- o_Tx_Byte holds its last value after the pulse; it is not cleared.
- Latency, write to empty FIFO with uart_tx idle:
  - i_Wr_DV sampled at edge n; count=1 after edge n.
  - FSM launches at edge n+1; o_Tx_DV high for the cycle after edge n+1.
- Back-to-back bytes:
  - i_Tx_Done is seen in WAIT_DONE at edge t; FSM enters IDLE.
  - Guard holds at edge t+1 (i_Tx_Done still 1).
  - Launch at edge t+2; o_Tx_DV high for the cycle after edge t+2.
- Reset mid-frame: FIFO is flushed and the FSM returns to IDLE. uart_tx has no reset and finishes its current byte. The IDLE guards prevent any launch until uart_tx reports Active=0 and Done=0.
- o_Busy is the combinational OR of the registered !empty and state!=IDLE, so it drops only after the last byte's Done.

Test Plan:
- Write 0x55 once into an empty FIFO with uart_tx idle (CLKS_PER_BIT=4): o_Tx_DV pulses 1 cycle with o_Tx_Byte=0x55 on the second edge after the write; serial line shows start, 10101010 LSB-first, stop; o_Busy falls after Done.
- Burst-write 0x01,0x02,0x03 on consecutive cycles: o_Count goes 1,2,3 then decrements per launch; three frames come out in order; each new DV pulse comes exactly 2 cycles after Done is seen, and never during uart_tx cleanup.
- DEPTH=4, uart_tx held busy, write 6 bytes 0xA0..0xA5: o_Full=1 after the 4th; 0xA4/0xA5 are dropped; o_Overflow=1 and stays 1; output stream is 0xA0..0xA3.
- Full FIFO with a write and a pop on the same edge: the write is dropped, o_Overflow sets, o_Count=DEPTH-1.
- Write DEPTH+3 bytes slowly enough to avoid full: pointers wrap and all bytes arrive in order, with o_Overflow=0.
- Assert i_Reset for 1 cycle mid data-bit with 2 bytes queued: o_Count=0, o_Empty=1, o_Overflow=0 next cycle. A byte written after reset launches only after uart_tx Done falls, and no queued pre-reset byte is ever sent.
